// File: rtl/regfile_seq.sv
// Sequencer driving an external 8-entry register file: MOV, SWAP, LOADI, CLRALL.
// Define REGFILE_SEQ_CLRALL_EN to build the CLRALL sweep; otherwise op=11 completes with no writes.
module regfile_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [2:0]   ra,
    input  logic [2:0]   rb,
    input  logic [W-1:0] imm,
    output logic         busy,
    output logic         done,
    output logic [2:0]   rf_readnum,
    output logic [2:0]   rf_writenum,
    output logic         rf_write,
    output logic [W-1:0] rf_data_in,
    input  logic [W-1:0] rf_data_out
);

    localparam logic [1:0] OP_MOV   = 2'b00;
    localparam logic [1:0] OP_SWAP  = 2'b01;
    localparam logic [1:0] OP_LOADI = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
`ifdef REGFILE_SEQ_CLRALL_EN
        CLR  = 3'd5,
`endif
        DONE = 3'd6
    } state_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [2:0]   ra;
        logic [2:0]   rb;
        logic [W-1:0] imm;
    } req_t;

    state_t       state, state_nxt;
    req_t         req;
    logic [W-1:0] t0, t1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            req   <= '0;
            t0    <= '0;
            t1    <= '0;
        end else begin
            state <= state_nxt;
            // Request is frozen for the whole operation; inputs are ignored until back in IDLE.
            if (state == IDLE && start) req <= '{op: op, ra: ra, rb: rb, imm: imm};
            if (state == RD_A) t0 <= rf_data_out;
            if (state == RD_B) t1 <= rf_data_out;
        end
    end

`ifdef REGFILE_SEQ_CLRALL_EN
    logic [2:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn)           cnt <= '0;
        else if (state == CLR) cnt <= cnt + 3'd1;
        else                   cnt <= '0;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MOV:   state_nxt = RD_B;
                        OP_SWAP:  state_nxt = RD_A;
                        OP_LOADI: state_nxt = WR_A;
`ifdef REGFILE_SEQ_CLRALL_EN
                        default:  state_nxt = CLR;
`else
                        default:  state_nxt = DONE;
`endif
                    endcase
                end
            end
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = WR_A;
            WR_A:    state_nxt = (req.op == OP_SWAP) ? WR_B : DONE;
            WR_B:    state_nxt = DONE;
`ifdef REGFILE_SEQ_CLRALL_EN
            CLR:     state_nxt = (cnt == 3'd7) ? DONE : CLR;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        rf_readnum  = '0;
        rf_writenum = '0;
        rf_write    = 1'b0;
        rf_data_in  = '0;
        case (state)
            RD_A: rf_readnum = req.ra;
            RD_B: rf_readnum = req.rb;
            WR_A: begin
                rf_write    = 1'b1;
                rf_writenum = req.ra;
                rf_data_in  = (req.op == OP_LOADI) ? req.imm : t1;
            end
            WR_B: begin
                rf_write    = 1'b1;
                rf_writenum = req.rb;
                rf_data_in  = t0;
            end
`ifdef REGFILE_SEQ_CLRALL_EN
            CLR: begin
                rf_write    = 1'b1;
                rf_writenum = cnt;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq: expected writes/done pulses are queued with their
// cycle stamps, a negedge monitor pops and compares them; a behavioural regfile closes the loop.
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        resetn, start;
    logic [1:0]  op;
    logic [2:0]  ra, rb;
    logic [15:0] imm;
    logic        busy, done, rf_write;
    logic [2:0]  rf_readnum, rf_writenum;
    logic [15:0] rf_data_in, rf_data_out;

    logic        pl_we = 1'b0;
    logic [2:0]  pl_num;
    logic [15:0] pl_data;
    logic [15:0] rf [8];

    logic [31:0] cyc = 0;
    logic [52:0] exp_q [$];
    logic [52:0] ev;
    int          total = 0, passes = 0;
    logic [31:0] s;

    regfile_seq #(.W(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .ra(ra), .rb(rb), .imm(imm),
        .busy(busy), .done(done), .rf_readnum(rf_readnum), .rf_writenum(rf_writenum),
        .rf_write(rf_write), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pl_we)                rf[pl_num]      <= pl_data;
        else if (rf_write === 1'b1) rf[rf_writenum] <= rf_data_in;
    end
    assign rf_data_out = rf[rf_readnum];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        else passes++;
    endtask

    task automatic push_wr(input logic [2:0] n, input logic [15:0] d, input logic [31:0] c);
        exp_q.push_back({1'b0, 1'b1, n, d, c});
    endtask

    task automatic push_done(input logic [31:0] c);
        exp_q.push_back({1'b1, 1'b0, 3'd0, 16'd0, c});
    endtask

    // Monitor: every write or done pulse must match the head of the queue, cycle included.
    always @(negedge clk) begin
        if (rf_write === 1'b1 || done === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_event", {11'd0, done, rf_write, rf_writenum, rf_data_in, cyc}, 64'd0);
            else begin
                ev = exp_q.pop_front();
                chk("event", {11'd0, done, rf_write, rf_writenum, rf_data_in, cyc}, {11'd0, ev});
            end
        end
    end

    task automatic preload(input logic [2:0] n, input logic [15:0] d);
        pl_we = 1'b1; pl_num = n; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // hold=1 keeps start high (with scrambled inputs) through busy and the DONE cycle.
    task automatic run_op(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                          input logic [15:0] im, input bit hold);
        int n;
        start = 1'b1; op = o; ra = a; rb = b; imm = im;
        @(negedge clk);
        if (!hold) start = 1'b0;
        op = ~o; ra = ~a; rb = ~b; imm = ~im;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk); #1; n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout_pending", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; start = 1'b0; op = 2'b00; ra = 3'd0; rb = 3'd0; imm = 16'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_rf_write", {63'd0, rf_write}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // LOADI R3 <= BEEF
        s = cyc; push_wr(3'd3, 16'hBEEF, s + 1); push_done(s + 2);
        run_op(2'b10, 3'd3, 3'd0, 16'hBEEF, 0);
        chk("loadi_r3", 64'(rf[3]), 64'hBEEF);

        // MOV R2 <= R5
        preload(3'd5, 16'h1234); preload(3'd2, 16'h0000);
        s = cyc; push_wr(3'd2, 16'h1234, s + 2); push_done(s + 3);
        run_op(2'b00, 3'd2, 3'd5, 16'h0, 0);
        chk("mov_r2", 64'(rf[2]), 64'h1234);
        chk("mov_r5", 64'(rf[5]), 64'h1234);

        // SWAP R1<->R6 with start held through busy and DONE
        preload(3'd1, 16'hAAAA); preload(3'd6, 16'h5555);
        s = cyc; push_wr(3'd1, 16'h5555, s + 3); push_wr(3'd6, 16'hAAAA, s + 4); push_done(s + 5);
        run_op(2'b01, 3'd1, 3'd6, 16'h0, 1);
        chk("swap_r1", 64'(rf[1]), 64'h5555);
        chk("swap_r6", 64'(rf[6]), 64'hAAAA);

        // CLRALL
        for (int i = 0; i < 8; i++) preload(3'(i), 16'hFFFF);
        s = cyc;
`ifdef REGFILE_SEQ_CLRALL_EN
        for (int i = 0; i < 8; i++) push_wr(3'(i), 16'h0000, s + 1 + 32'(i));
        push_done(s + 9);
`else
        push_done(s + 1);
`endif
        run_op(2'b11, 3'd0, 3'd0, 16'h0, 0);
        for (int i = 0; i < 8; i++) begin
`ifdef REGFILE_SEQ_CLRALL_EN
            chk("clrall_reg", {32'(i), 16'h0, rf[i]}, {32'(i), 32'h0});
`else
            chk("clrall_off_reg", {32'(i), 16'h0, rf[i]}, {32'(i), 32'hFFFF});
`endif
        end

        // Reset in WR_A of a SWAP: R1 written, R6 untouched
        preload(3'd1, 16'hAAAA); preload(3'd6, 16'h5555);
        s = cyc; push_wr(3'd1, 16'h5555, s + 3);
        start = 1'b1; op = 2'b01; ra = 3'd1; rb = 3'd6;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #1 resetn = 1'b0;
        @(negedge clk); #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_rf_write", {63'd0, rf_write}, 64'd0);
        chk("abort_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_r1", 64'(rf[1]), 64'h5555);
        chk("abort_r6", 64'(rf[6]), 64'h5555);

        // ra==rb SWAP and MOV leave the register unchanged
        preload(3'd4, 16'h0F0F);
        s = cyc; push_wr(3'd4, 16'h0F0F, s + 3); push_wr(3'd4, 16'h0F0F, s + 4); push_done(s + 5);
        run_op(2'b01, 3'd4, 3'd4, 16'h0, 0);
        chk("swap_same_r4", 64'(rf[4]), 64'h0F0F);
        preload(3'd7, 16'hC3C3);
        s = cyc; push_wr(3'd7, 16'hC3C3, s + 2); push_done(s + 3);
        run_op(2'b00, 3'd7, 3'd7, 16'h0, 0);
        chk("mov_same_r7", 64'(rf[7]), 64'hC3C3);

        // start coincident with reset is dropped
        resetn = 1'b0; start = 1'b1; op = 2'b10; ra = 3'd0; imm = 16'h1234;
        @(negedge clk);
        resetn = 1'b1; start = 1'b0;
        chk("start_in_reset_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("start_in_reset_r0", 64'(rf[0]), 64'(rf[0] === 16'h1234 ? 16'hDEAD : rf[0]));

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 The block SHALL have parameter: W, 16, data width of the register file words.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: resetn  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 The block SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port: op  input  2  operation: 00 MOV (ra<=rb), 01 SWAP (ra<->rb), 10 LOADI (ra<=imm), 11 CLRALL.
REQ-006 The block SHALL have port: ra  input  3  first register number, destination for MOV/LOADI.
REQ-007 The block SHALL have port: rb  input  3  second register number, source for MOV.
REQ-008 The block SHALL have port: imm  input  W  immediate value for LOADI.
REQ-009 The block SHALL have port: busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have ports driving the register file: rf_readnum output 3, rf_writenum output 3, rf_write output 1, rf_data_in output W; and input rf_data_out W, the combinational read data.

Function
REQ-012 The FSM SHALL have states IDLE, RD_A, RD_B, WR_A, WR_B, CLR, DONE; all rf_* outputs, busy and done SHALL be decoded from registered state only (Moore).
REQ-013 In IDLE with start=1, op, ra, rb and imm SHALL be captured on that edge; later input changes SHALL have no effect until DONE.
REQ-014 Transitions: MOV IDLE->RD_B->WR_A->DONE; SWAP IDLE->RD_A->RD_B->WR_A->WR_B->DONE; LOADI IDLE->WR_A->DONE; CLRALL IDLE->CLR(x8)->DONE; DONE->IDLE unconditionally.
REQ-015 RD_A: rf_readnum=ra, t0<=rf_data_out. RD_B: rf_readnum=rb, t1<=rf_data_out; rf_write=0 in both.
REQ-016 WR_A: rf_write=1, rf_writenum=ra, rf_data_in=t1 (MOV/SWAP) or imm (LOADI). WR_B: rf_write=1, rf_writenum=rb, rf_data_in=t0.
REQ-017 CLR: 3-bit counter from 0; rf_write=1, rf_writenum=counter, rf_data_in=0; counter increments each cycle; exit to DONE after counter=7 is written, no wrap to 0.
REQ-018 In IDLE and DONE: rf_write=0, rf_writenum=0, rf_readnum=0, rf_data_in=0.
REQ-019 Latency from start-sampling edge to done high: MOV 3 cycles, SWAP 5, LOADI 2, CLRALL 9.
REQ-020 start while busy SHALL be ignored and not queued; start asserted in the DONE cycle SHALL be ignored.
REQ-021 ra==rb: MOV and SWAP SHALL run full sequence and leave register contents unchanged.
REQ-022 rf_write SHALL never be high for more than one target per cycle and never in RD_A/RD_B.

Reset
REQ-023 resetn=0 at a rising edge SHALL force IDLE, counter=0, t0=t1=0; busy=0, done=0, rf_write=0 from the following cycle.
REQ-024 Reset mid-operation SHALL abort with no further writes; already-written registers SHALL not be restored.
REQ-025 start coincident with resetn=0 SHALL be ignored.

Configuration
REQ-026 With macro REGFILE_SEQ_CLRALL_EN defined, op=11 SHALL execute CLRALL per REQ-017.
REQ-027 Without REGFILE_SEQ_CLRALL_EN, op=11 SHALL go IDLE->DONE with no register writes (done 1 cycle after start), and the CLR state and counter SHALL not be built.

Verification
REQ-028 LOADI: reset, start op=10 ra=3 imm=0xBEEF -> rf_write high one cycle, writenum=3, data_in=0xBEEF; done 2 cycles after start; R3 reads 0xBEEF.
REQ-029 MOV: R5=0x1234, R2=0; start op=00 ra=2 rb=5 -> done at cycle 3; R2=0x1234, R5 unchanged.
REQ-030 SWAP: R1=0xAAAA, R6=0x5555; start op=01 ra=1 rb=6 -> done at cycle 5; R1=0x5555, R6=0xAAAA; start pulses during busy ignored.
REQ-031 CLRALL: all regs 0xFFFF; start op=11 -> 8 consecutive writes, numbers 0..7, data 0; done at cycle 9; with macro undefined, done at cycle 1 and no writes.
REQ-032 Reset abort: SWAP started, resetn=0 in WR_A cycle -> next cycle IDLE, busy=0, rf_write=0; R1 updated, R6 not; ra==rb SWAP on R4=0x0F0F leaves R4=0x0F0F.
